// File: rtl/resampler_out_fifo.sv
// Elastic buffer behind the resampler. It absorbs the unthrottled sample stream,
// presents it on a valid/ready sink, and turns the fill error into the
// resampler's ppm correction. It also keeps sticky overflow/underflow flags.
module resampler_out_fifo #(
  parameter int                 DATA_WIDTH  = 16,
  parameter int                 DEPTH       = 32,
  parameter int                 PRIME_LEVEL = 16,
  parameter logic signed [31:0] PPM_NOMINAL = 32'sd0,
  parameter logic [31:0]        PPM_GAIN    = 32'd1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic signed [31:0]        ppm_out,
  output logic                      ovf_sticky,
  output logic                      udf_sticky,
  input  logic                      clr_flags
);

  // state | meaning
  // PRIME | filling up to PRIME_LEVEL; sink sees nothing, ppm held nominal
  // RUN   | streaming to the sink; ppm follows the fill error

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [63:0] P_MAX = 64'sd2147483647;
  localparam logic signed [63:0] P_MIN = -64'sd2147483648;

  typedef enum logic {PRIME, RUN} state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic                   rd_en, wr_en, drop, udf_ev;
  logic [AW:0]            fill_next;
  logic signed [AW+1:0]   err;
  logic signed [63:0]     err_w, p;
  logic signed [31:0]     ppm_sat;

  assign out_data = mem[rd_ptr];

  // Transfer decisions, next fill and next state for the coming edge.
  always_comb begin
    rd_en  = out_valid & out_ready;
    wr_en  = in_valid & ((fill_level < (AW+1)'(DEPTH)) | rd_en);
    drop   = in_valid & ~wr_en;
    udf_ev = (state == RUN) && (fill_level == '0) && out_ready;

    fill_next = fill_level;
    if (wr_en && !rd_en)
      fill_next = fill_level + (AW+1)'(1);
    else if (!wr_en && rd_en)
      fill_next = fill_level - (AW+1)'(1);

    state_next = state;
    if (state == PRIME && fill_level >= (AW+1)'(PRIME_LEVEL))
      state_next = RUN;
    else if (state == RUN && udf_ev)
      state_next = PRIME;
  end

  // Rate correction: fuller FIFO pulls ppm down, clamped to 32-bit signed range.
  always_comb begin
    err   = $signed({1'b0, fill_level}) - $signed((AW+2)'(PRIME_LEVEL));
    err_w = {{(62-AW){err[AW+1]}}, err};
    p     = $signed({{32{PPM_NOMINAL[31]}}, PPM_NOMINAL})
          - err_w * $signed({32'd0, PPM_GAIN});
    if (p > P_MAX)
      ppm_sat = 32'sh7fff_ffff;
    else if (p < P_MIN)
      ppm_sat = 32'sh8000_0000;
    else
      ppm_sat = p[31:0];
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_data;
  end

  // Pointers and explicit fill count so full and empty stay distinct.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      fill_level <= fill_next;
    end
  end

  // Priming FSM with registered sink valid, ppm and sticky flags (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PRIME;
      out_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
      ppm_out    <= PPM_NOMINAL;
    end else begin
      state      <= state_next;
      out_valid  <= (state_next == RUN) && (fill_next != '0);
      ovf_sticky <= drop | (ovf_sticky & ~clr_flags);
      udf_sticky <= udf_ev | (udf_sticky & ~clr_flags);
      ppm_out    <= (state_next == RUN) ? ppm_sat : PPM_NOMINAL;
    end
  end

endmodule

// File: tb/tb_resampler_out_fifo.sv
// Randomized bench for resampler_out_fifo against a queue-based reference model.
// A second instance with a huge gain exercises ppm saturation.
module tb_resampler_out_fifo;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [15:0]        in_data;
  logic               in_valid;
  logic               out_ready;
  logic               clr_flags;

  logic [15:0]        out_data, out_data_s;
  logic               out_valid, out_valid_s;
  logic [5:0]         fill_level, fill_level_s;
  logic signed [31:0] ppm_out, ppm_out_s;
  logic               ovf_sticky, ovf_sticky_s;
  logic               udf_sticky, udf_sticky_s;

  int n_checks = 0;
  int n_errors = 0;

  int      q[$];
  bit      priming;
  bit      ovf_m, udf_m;
  longint  ppm_m, ppm_s_m;

  always #5 clk = ~clk;

  resampler_out_fifo #(
    .DATA_WIDTH(16), .DEPTH(32), .PRIME_LEVEL(16),
    .PPM_NOMINAL(32'sd0), .PPM_GAIN(32'd1000)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .ppm_out(ppm_out),
    .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .clr_flags(clr_flags)
  );

  resampler_out_fifo #(
    .DATA_WIDTH(16), .DEPTH(32), .PRIME_LEVEL(16),
    .PPM_NOMINAL(32'sd0), .PPM_GAIN(32'h4000_0000)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .fill_level(fill_level_s), .ppm_out(ppm_out_s),
    .ovf_sticky(ovf_sticky_s), .udf_sticky(udf_sticky_s), .clr_flags(clr_flags)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint ppm_ref(input int fill, input longint gain);
    longint pv;
    pv = -((longint'(fill) - 16) * gain);
    if (pv > 64'sd2147483647)  pv = 64'sd2147483647;
    if (pv < -64'sd2147483648) pv = -64'sd2147483648;
    return pv;
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit iv, input bit ordy, input bit clr, input bit rst);
    logic [15:0] d;
    int  sz;
    bit  ov, rd, wok, uev, nxt_prime, exp_valid;
    d         = 16'($urandom);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr_flags = clr;
    rst_n     = !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      priming = 1'b1;
      ovf_m   = 1'b0;
      udf_m   = 1'b0;
      ppm_m   = 0;
      ppm_s_m = 0;
    end else begin
      sz  = q.size();
      ov  = !priming && sz > 0;
      rd  = ov && ordy;
      wok = iv && (sz < 32 || rd);
      uev = !priming && sz == 0 && ordy;
      nxt_prime = priming;
      if (priming && sz >= 16)  nxt_prime = 1'b0;
      else if (!priming && uev) nxt_prime = 1'b1;
      ppm_m   = nxt_prime ? 0 : ppm_ref(sz, 1000);
      ppm_s_m = nxt_prime ? 0 : ppm_ref(sz, 64'sd1073741824);
      ovf_m   = (ovf_m && !clr) || (iv && !wok);
      udf_m   = (udf_m && !clr) || uev;
      if (rd)  void'(q.pop_front());
      if (wok) q.push_back(int'(d));
      priming = nxt_prime;
    end
    exp_valid = !priming && q.size() > 0;
    check("out_valid", out_valid, exp_valid);
    check("fill_level", fill_level, q.size());
    if (exp_valid) check("out_data", out_data, q[0]);
    check("ppm_out", ppm_out, ppm_m);
    check("ppm_out_sat", ppm_out_s, ppm_s_m);
    check("ovf_sticky", ovf_sticky, ovf_m);
    check("udf_sticky", udf_sticky, udf_m);
  endtask

  task automatic run_phase(input int cycles, input int pv, input int pr, input int pc);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(99) < pv, $urandom_range(99) < pr, $urandom_range(99) < pc, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    run_phase(25, 100, 100, 0);   // priming then steady streaming
    run_phase(40, 100, 0, 0);     // fill to full, overflow, saturated ppm
    run_phase(15, 100, 100, 0);   // full with simultaneous read/write, wraps
    run_phase(50, 0, 100, 0);     // drain to empty, underflow, back to PRIME
    run_phase(5, 0, 0, 100);      // clear flags with no events
    run_phase(300, 50, 50, 5);
    run_phase(300, 60, 40, 5);
    run_phase(40, 100, 20, 0);
    step(1, 0, 0, 1);             // single-edge reset mid-run
    run_phase(30, 100, 100, 0);   // re-prime
    run_phase(200, 55, 50, 5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
